// File: rtl/detector_jogada_pkg.sv
// Shared state encoding and default debounce length for the answer-button detector.
package detector_jogada_pkg;

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    FILTRA_PRESSAO = 3'd1,
    EMITE          = 3'd2,
    ESPERA_SOLTAR  = 3'd3,
    FILTRA_SOLTURA = 3'd4
  } estado_t;

  // 1 ms at 50 MHz
  localparam int DEBOUNCE_PADRAO = 50000;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchroniser bringing the raw button levels into the clock domain.
module sincronizador #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] dado_i,
  output logic [LARGURA-1:0] dado_o
);

  logic [LARGURA-1:0] meta_q;
  logic [LARGURA-1:0] sinc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= dado_i;
      sinc_q <= meta_q;
    end
  end

  assign dado_o = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounces the answer buttons, accepts a single lone press while armed, emits one pulse
// plus a held one-hot code, then waits for a debounced full release before re-arming.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                jogada_feita,
  output logic [N_BOTOES-1:0] jogada,
  output logic [2:0]          db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] sinc;

  estado_t             estado_q, estado_d;
  logic [CW-1:0]       cont_q, cont_d, cont_inc;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                feita_q, feita_d;
  logic                um_bit;

  sincronizador #(.LARGURA(N_BOTOES)) u_sinc (
    .clock  (clock),
    .reset  (reset),
    .dado_i (botoes),
    .dado_o (sinc)
  );

  assign um_bit   = ($countones(sinc) == 1);
  assign cont_inc = (cont_q == CONT_MAX) ? cont_q : cont_q + 1'b1;

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    cand_d   = cand_q;
    jogada_d = jogada_q;

    unique case (estado_q)
      OCIOSO: begin
        if (habilita && um_bit) begin
          cand_d   = sinc;
          estado_d = FILTRA_PRESSAO;
        end
      end
      FILTRA_PRESSAO: begin
        if (!habilita || (sinc != cand_q)) begin
          estado_d = OCIOSO;
        end else if (cont_q == CONT_MAX) begin
          estado_d = EMITE;
          jogada_d = cand_q;
        end else begin
          cont_d = cont_inc;
        end
      end
      EMITE: begin
        estado_d = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (sinc == '0) estado_d = FILTRA_SOLTURA;
      end
      FILTRA_SOLTURA: begin
        if (sinc != '0) begin
          estado_d = ESPERA_SOLTAR;
        end else if (cont_q == CONT_MAX) begin
          estado_d = OCIOSO;
        end else begin
          cont_d = cont_inc;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    // every state starts its stability window from zero
    if (estado_d != estado_q) cont_d = '0;

    feita_d = (estado_d == EMITE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
      cand_q   <= '0;
      jogada_q <= '0;
      feita_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      cand_q   <= cand_d;
      jogada_q <= jogada_d;
      feita_q  <= feita_d;
    end
  end

  assign jogada_feita = feita_q;
  assign jogada       = jogada_q;
  assign db_estado    = estado_q;

endmodule
